// File: rtl/linear_pkg.sv
// linear_pkg: shared types, defaults and the saturating truncate helper
// for the sequential linear layer (linear_seq, linear_requant).
package linear_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } linear_state_t;

  localparam int DEF_ROWS         = 16;
  localparam int DEF_IN_FEATURES  = 16;
  localparam int DEF_OUT_FEATURES = 16;
  localparam int DEF_DATA_SIZE    = 8;
  localparam int DEF_SHIFT        = 0;

  // Clamp a wide signed value into the range of a dw-bit signed number.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] x,
                                                   input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi)      sat_trunc = hi;
    else if (x < lo) sat_trunc = lo;
    else             sat_trunc = x;
  endfunction

endpackage

// File: rtl/linear_requant.sv
// linear_requant: one output lane of linear_seq.
// Arithmetic shift -> bias add -> saturate -> optional ReLU.
// Build option: define LINEAR_SEQ_RELU_EN to clamp negative results to 0.
module linear_requant
  import linear_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ACC_SIZE  = 2 * DEF_DATA_SIZE + 4,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic signed [ACC_SIZE-1:0]  i_acc,
  input  logic signed [DATA_SIZE-1:0] i_bias,
  output logic signed [DATA_SIZE-1:0] o_out
);

  logic signed [ACC_SIZE-1:0]  w_shifted;
  logic signed [ACC_SIZE:0]    w_sum;
  logic signed [DATA_SIZE-1:0] w_sat;

  // Floor-toward-minus-infinity requantisation, then one extra bit so the
  // bias add itself cannot wrap before saturation.
  assign w_shifted = i_acc >>> SHIFT;
  assign w_sum     = (ACC_SIZE+1)'(w_shifted) + (ACC_SIZE+1)'(i_bias);
  assign w_sat     = DATA_SIZE'(sat_trunc(64'(w_sum), DATA_SIZE));

`ifdef LINEAR_SEQ_RELU_EN
  assign o_out = w_sat[DATA_SIZE-1] ? '0 : w_sat;
`else
  assign o_out = w_sat;
`endif

endmodule

// File: rtl/linear_seq.sv
// linear_seq: sequential linear layer, out = sat((A*W >>> SHIFT) + bias).
// OUT_FEATURES parallel MACs consume one activation column per cycle;
// each row takes IN_FEATURES MAC cycles plus one WRITE cycle.
// Build option: LINEAR_SEQ_RELU_EN (see linear_requant) adds a ReLU.
module linear_seq
  import linear_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int IN_FEATURES  = DEF_IN_FEATURES,
  parameter int OUT_FEATURES = DEF_OUT_FEATURES,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int ACC_SIZE     = 2 * DATA_SIZE + $clog2(IN_FEATURES),
  parameter int SHIFT        = DEF_SHIFT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic signed [DATA_SIZE-1:0] mat_a [ROWS][IN_FEATURES],
  input  logic signed [DATA_SIZE-1:0] wt [IN_FEATURES][OUT_FEATURES],
  input  logic signed [DATA_SIZE-1:0] bias [OUT_FEATURES],
  output logic signed [DATA_SIZE-1:0] out_matrix [ROWS][OUT_FEATURES]
);

  localparam int KW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(IN_FEATURES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

  linear_state_t              r_state;
  logic [KW-1:0]              r_k;
  logic [RW-1:0]              r_r;
  logic                       r_busy;
  logic                       r_done;
  logic signed [ACC_SIZE-1:0] r_acc [OUT_FEATURES];
  logic signed [DATA_SIZE-1:0] r_out [ROWS][OUT_FEATURES];

  logic signed [ACC_SIZE-1:0]  w_prod [OUT_FEATURES];
  logic signed [DATA_SIZE-1:0] w_lane [OUT_FEATURES];

  assign busy       = r_busy;
  assign done       = r_done;
  assign out_matrix = r_out;

  // Full-precision products of the current activation with weight row k.
  always_comb begin
    for (int j = 0; j < OUT_FEATURES; j++) begin
      w_prod[j] = ACC_SIZE'(mat_a[r_r][r_k] * wt[r_k][j]);
    end
  end

  genvar gj;
  generate
    for (gj = 0; gj < OUT_FEATURES; gj++) begin : g_lane
      linear_requant #(
        .DATA_SIZE(DATA_SIZE),
        .ACC_SIZE (ACC_SIZE),
        .SHIFT    (SHIFT)
      ) u_requant (
        .i_acc (r_acc[gj]),
        .i_bias(bias[gj]),
        .o_out (w_lane[gj])
      );
    end
  endgenerate

  // Control FSM with MAC accumulators and the result register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int j = 0; j < OUT_FEATURES; j++) r_acc[j] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int j = 0; j < OUT_FEATURES; j++) r_out[r][j] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int j = 0; j < OUT_FEATURES; j++) r_acc[j] <= '0;
            r_r     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          for (int j = 0; j < OUT_FEATURES; j++) r_acc[j] <= r_acc[j] + w_prod[j];
          if (r_k == K_LAST) begin
            r_state <= ST_WRITE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        ST_WRITE: begin
          for (int j = 0; j < OUT_FEATURES; j++) begin
            r_out[r_r][j] <= w_lane[j];
            r_acc[j]      <= '0;
          end
          r_k <= '0;
          if (r_r == R_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_r     <= r_r + RW'(1);
            r_state <= ST_MAC;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
